// File: rtl/dmem_arb_pkg.sv
// Shared types, constants and address helpers for the two-requester data
// memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int DEFAULT_DEPTH      = 33;
    localparam int DEFAULT_ADDR_SHIFT = 3;

    // Full-width unsigned check: upper address bits are never truncated, so a
    // huge address is out of range rather than aliasing onto a low index.
    function automatic logic addr_bad(input logic [63:0] addr,
                                      input int unsigned shift,
                                      input int unsigned depth);
        logic [63:0] mask;
        mask = (64'd1 << shift) - 64'd1;
        return ((addr & mask) != 64'd0) || ((addr >> shift) >= 64'(depth));
    endfunction

    function automatic logic [63:0] word_index(input logic [63:0] addr,
                                               input int unsigned shift);
        return addr >> shift;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational two-way round-robin grant: a lone requester always wins, a tie
// goes to the requester that was not granted last.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port 64-bit data memory between the CPU (r0) and the
// debug/DMA loader (r1): round-robin accept, one strobe per access, response.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid and payload must hold until then, and ready never depends on a
// transfer completing in the same cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_SHIFT = DEFAULT_ADDR_SHIFT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_req_valid,
    output logic        r0_req_ready,
    input  logic        r0_req_write,
    input  logic [63:0] r0_req_addr,
    input  logic [63:0] r0_req_wdata,
    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,
    output logic [63:0] r0_rsp_rdata,
    output logic        r0_rsp_err,

    input  logic        r1_req_valid,
    output logic        r1_req_ready,
    input  logic        r1_req_write,
    input  logic [63:0] r1_req_addr,
    input  logic [63:0] r1_req_wdata,
    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,
    output logic [63:0] r1_rsp_rdata,
    output logic        r1_rsp_err,

    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    input  logic [63:0] mem_read_data,

    output state_e      dbg_state
);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q, id_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [63:0] mem_address_q, mem_address_d;
    logic [63:0] mem_write_data_q, mem_write_data_d;

    logic [1:0]  grant;
    logic [1:0]  accept;
    logic        sel_write;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic        sel_bad;
    logic        rsp_hs;
    logic        rsp_active;
    logic [63:0] rsp_data;

    rr_arbiter_2 u_rr (
        .valid      ({r1_req_valid, r0_req_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Reset wins over a same-cycle request, so nothing is reported as accepted.
    assign accept       = (state_q == IDLE && !rst) ? grant : 2'b00;
    assign r0_req_ready = accept[0];
    assign r1_req_ready = accept[1];

    assign sel_write = accept[1] ? r1_req_write : r0_req_write;
    assign sel_addr  = accept[1] ? r1_req_addr  : r0_req_addr;
    assign sel_wdata = accept[1] ? r1_req_wdata : r0_req_wdata;
    assign sel_bad   = addr_bad(sel_addr, ADDR_SHIFT, DEPTH);

    assign rsp_active = (state_q == RESP);
    assign rsp_hs     = rsp_active && (id_q ? r1_rsp_ready : r0_rsp_ready);

    // Memory is idle during RESP, so mem_read_data is still the loaded word.
    assign rsp_data = (!err_q && !write_q) ? mem_read_data : 64'd0;

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        id_d             = id_q;
        write_d          = write_q;
        err_d            = err_q;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        mem_address_d    = 64'd0;
        mem_write_data_d = 64'd0;

        case (state_q)
            IDLE: begin
                if (accept != 2'b00) begin
                    id_d         = accept[1] ? REQ_DBG : REQ_CPU;
                    last_grant_d = accept[1] ? REQ_DBG : REQ_CPU;
                    write_d      = sel_write;
                    err_d        = sel_bad;
                    if (sel_bad) begin
                        state_d = RESP;
                    end else begin
                        state_d          = ACCESS;
                        mem_read_d       = !sel_write;
                        mem_write_d      = sel_write;
                        mem_address_d    = word_index(sel_addr, ADDR_SHIFT);
                        mem_write_data_d = sel_wdata;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            last_grant_q     <= REQ_DBG;
            id_q             <= REQ_CPU;
            write_q          <= 1'b0;
            err_q            <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= 64'd0;
            mem_write_data_q <= 64'd0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            id_q             <= id_d;
            write_q          <= write_d;
            err_q            <= err_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

    assign r0_rsp_valid = rsp_active && (id_q == REQ_CPU);
    assign r1_rsp_valid = rsp_active && (id_q == REQ_DBG);
    assign r0_rsp_rdata = r0_rsp_valid ? rsp_data : 64'd0;
    assign r1_rsp_rdata = r1_rsp_valid ? rsp_data : 64'd0;
    assign r0_rsp_err   = r0_rsp_valid && err_q;
    assign r1_rsp_err   = r1_rsp_valid && err_q;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DEPTH = 33;

    logic        clk;
    logic        rst;
    logic        r0_req_valid, r0_req_ready, r0_req_write;
    logic [63:0] r0_req_addr, r0_req_wdata;
    logic        r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
    logic [63:0] r0_rsp_rdata;
    logic        r1_req_valid, r1_req_ready, r1_req_write;
    logic [63:0] r1_req_addr, r1_req_wdata;
    logic        r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
    logic [63:0] r1_rsp_rdata;
    logic        mem_read, mem_write;
    logic [63:0] mem_address, mem_write_data, mem_read_data;
    state_e      dbg_state;

    int n_tests;
    int n_fail;

    dmem_arbiter #(.DEPTH(DEPTH), .ADDR_SHIFT(3)) dut (
        .clk(clk), .rst(rst),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r0_req_write(r0_req_write), .r0_req_addr(r0_req_addr),
        .r0_req_wdata(r0_req_wdata), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_rsp_rdata(r0_rsp_rdata),
        .r0_rsp_err(r0_rsp_err),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r1_req_write(r1_req_write), .r1_req_addr(r1_req_addr),
        .r1_req_wdata(r1_req_wdata), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_rsp_rdata(r1_rsp_rdata),
        .r1_rsp_err(r1_rsp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory environment ----------------
    logic [63:0] env_mem [DEPTH];

    always @(posedge clk) begin
        if (mem_write && mem_address < 64'(DEPTH)) env_mem[mem_address[5:0]] <= mem_write_data;
        if (mem_read && mem_address < 64'(DEPTH)) mem_read_data <= env_mem[mem_address[5:0]];
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One outstanding access at a time; its phase is the number of cycles since
    // acceptance: strobe one cycle after, response from two (one for errors).
    logic [63:0] ref_mem [DEPTH];
    bit          busy;
    int          age;
    bit          last_grant;
    bit          cur_id, cur_write, cur_err;
    int          cur_idx;
    logic [63:0] cur_wdata, exp_rdata;

    always @(negedge clk) begin
        bit e_r0, e_r1, strobe, rsp_on, hs;
        logic [63:0] a;
        e_r0   = !rst && !busy && r0_req_valid && (!r1_req_valid || last_grant);
        e_r1   = !rst && !busy && r1_req_valid && (!r0_req_valid || !last_grant);
        strobe = busy && !cur_err && age == 1;
        rsp_on = busy && (age >= (cur_err ? 1 : 2));

        check("r0_req_ready", 64'(r0_req_ready), 64'(e_r0));
        check("r1_req_ready", 64'(r1_req_ready), 64'(e_r1));
        check("mem_read", 64'(mem_read), 64'(strobe && !cur_write));
        check("mem_write", 64'(mem_write), 64'(strobe && cur_write));
        if (strobe) begin
            check("mem_address", mem_address, 64'(cur_idx));
            if (cur_write) check("mem_write_data", mem_write_data, cur_wdata);
        end
        check("r0_rsp_valid", 64'(r0_rsp_valid), 64'(rsp_on && cur_id == 1'b0));
        check("r1_rsp_valid", 64'(r1_rsp_valid), 64'(rsp_on && cur_id == 1'b1));
        if (rsp_on) begin
            check("rsp_rdata", cur_id ? r1_rsp_rdata : r0_rsp_rdata,
                  (cur_err || cur_write) ? 64'd0 : exp_rdata);
            check("rsp_err", 64'(cur_id ? r1_rsp_err : r0_rsp_err), 64'(cur_err));
        end

        // advance the model across the coming rising edge
        if (rst) begin
            if (strobe && cur_write) ref_mem[cur_idx] = cur_wdata;
            busy       = 1'b0;
            last_grant = 1'b1;
        end else if (busy) begin
            if (strobe) begin
                if (cur_write) ref_mem[cur_idx] = cur_wdata;
                else exp_rdata = ref_mem[cur_idx];
            end
            hs = rsp_on && (cur_id ? r1_rsp_ready : r0_rsp_ready);
            if (hs) busy = 1'b0;
            else age++;
        end else if (e_r0 || e_r1) begin
            cur_id     = e_r1;
            a          = e_r1 ? r1_req_addr : r0_req_addr;
            cur_write  = e_r1 ? r1_req_write : r0_req_write;
            cur_wdata  = e_r1 ? r1_req_wdata : r0_req_wdata;
            cur_err    = (a % 8 != 0) || (a / 8 >= 64'(DEPTH));
            cur_idx    = cur_err ? 0 : int'(a / 8);
            busy       = 1'b1;
            age        = 1;
            last_grant = cur_id;
        end
    end

    // grant order as observed on the DUT, for the fairness scenario
    logic [0:0] got_q[$];
    logic [0:0] exp_q[$];
    always @(negedge clk) begin
        if (r0_req_ready) got_q.push_back(1'b0);
        if (r1_req_ready) got_q.push_back(1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input bit id, input bit wr, input logic [63:0] addr,
                             input logic [63:0] wd);
        bit done;
        done = 1'b0;
        if (id) begin
            r1_req_valid = 1'b1; r1_req_write = wr; r1_req_addr = addr; r1_req_wdata = wd;
        end else begin
            r0_req_valid = 1'b1; r0_req_write = wr; r0_req_addr = addr; r0_req_wdata = wd;
        end
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (id ? r1_req_ready : r0_req_ready) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout r%0d: actual=no ready required=ready", id);
        end
        @(posedge clk);
        #1;
        if (id) r1_req_valid = 1'b0;
        else r0_req_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7) return 64'($urandom_range(0, DEPTH - 1)) * 8;
        if (sel == 7) return 64'($urandom_range(0, 300));
        if (sel == 8) return 64'($urandom_range(DEPTH, DEPTH + 4)) * 8;
        return {32'($urandom), 29'($urandom), 3'b000};
    endfunction

    task automatic rand_traffic(input bit id, input int n);
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 3));
            drive_req(id, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
        end
    endtask

    // ---------------- main sequence ----------------
    bit rand_done;

    initial begin
        logic [63:0] v;
        n_tests = 0; n_fail = 0;
        busy = 1'b0; age = 0; last_grant = 1'b1;
        cur_id = 0; cur_write = 0; cur_err = 0; cur_idx = 0;
        cur_wdata = 0; exp_rdata = 0;
        for (int i = 0; i < DEPTH; i++) begin
            v = {$urandom, $urandom};
            if (i == 2) v = 64'hDEAD;
            ref_mem[i] = v;
            env_mem[i] <= v;
        end
        rst = 1'b1;
        r0_req_valid = 0; r0_req_write = 0; r0_req_addr = 0; r0_req_wdata = 0;
        r1_req_valid = 0; r1_req_write = 0; r1_req_addr = 0; r1_req_wdata = 0;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        mem_read_data = 64'd0;
        tick(3);
        rst = 1'b0;

        // reset state
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        check("reset_mem_read", 64'(mem_read), 64'd0);
        check("reset_mem_write", 64'(mem_write), 64'd0);
        check("reset_mem_address", mem_address, 64'd0);
        check("reset_rsp_valid", 64'({r0_rsp_valid, r1_rsp_valid}), 64'd0);

        // load only
        drive_req(1'b0, 1'b0, 64'h10, 64'd0);
        check("load_strobe", 64'(mem_read), 64'd1);
        check("load_address", mem_address, 64'd2);
        tick(1);
        check("load_rsp_valid", 64'(r0_rsp_valid), 64'd1);
        check("load_rdata", r0_rsp_rdata, 64'hDEAD);
        check("load_err", 64'(r0_rsp_err), 64'd0);
        tick(1);

        // store then load back through r1
        drive_req(1'b1, 1'b1, 64'h18, 64'h1234);
        check("store_write", 64'(mem_write), 64'd1);
        check("store_read", 64'(mem_read), 64'd0);
        check("store_address", mem_address, 64'd3);
        check("store_wdata", mem_write_data, 64'h1234);
        tick(1);
        check("store_rdata", r1_rsp_rdata, 64'd0);
        tick(1);
        drive_req(1'b1, 1'b0, 64'h18, 64'd0);
        tick(1);
        check("reload_rdata", r1_rsp_rdata, 64'h1234);
        tick(1);

        // errors: misaligned, index == DEPTH, huge upper bits
        drive_req(1'b0, 1'b0, 64'h0C, 64'd0);
        check("misalign_err", 64'(r0_rsp_err), 64'd1);
        check("misalign_rdata", r0_rsp_rdata, 64'd0);
        check("misalign_nostrobe", 64'(mem_read | mem_write), 64'd0);
        tick(1);
        drive_req(1'b0, 1'b0, 64'h108, 64'd0);
        check("oor_err", 64'(r0_rsp_err), 64'd1);
        check("oor_nostrobe", 64'(mem_read | mem_write), 64'd0);
        tick(1);
        drive_req(1'b1, 1'b1, 64'h8000_0000_0000_0010, 64'h55);
        check("upper_bits_err", 64'(r1_rsp_err), 64'd1);
        check("upper_bits_nostrobe", 64'(mem_write), 64'd0);
        tick(1);

        // tie fairness from a fresh reset
        rst = 1'b1; tick(1); rst = 1'b0;
        got_q.delete();
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        fork
            begin
                drive_req(1'b0, 1'b0, 64'h00, 64'd0);
                drive_req(1'b0, 1'b0, 64'h08, 64'd0);
            end
            begin
                drive_req(1'b1, 1'b0, 64'h20, 64'd0);
                drive_req(1'b1, 1'b0, 64'h28, 64'd0);
            end
        join
        tick(3);
        check("tie_grant_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check("tie_grant_order", 64'(got_q[i]), 64'(exp_q[i]));

        // backpressure on r0 while r1 waits
        r0_rsp_ready = 1'b0;
        fork
            begin
                drive_req(1'b0, 1'b0, 64'h10, 64'd0);
                tick(1);
                for (int i = 0; i < 5; i++) begin
                    check("bp_rsp_valid", 64'(r0_rsp_valid), 64'd1);
                    check("bp_rdata", r0_rsp_rdata, 64'hDEAD);
                    check("bp_r1_blocked", 64'(r1_req_ready), 64'd0);
                    tick(1);
                end
                r0_rsp_ready = 1'b1;
                check("bp_r1_blocked_hs", 64'(r1_req_ready), 64'd0);
                tick(1);
                check("bp_r1_granted_after", 64'(r1_req_ready), 64'd1);
            end
            begin
                tick(1);
                drive_req(1'b1, 1'b0, 64'h08, 64'd0);
            end
        join
        tick(3);

        // reset during the access cycle of a store
        drive_req(1'b0, 1'b1, 64'h20, 64'hCAFE);
        check("rst_access_strobe", 64'(mem_write), 64'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_state_idle", 64'(dbg_state), 64'(IDLE));
        check("rst_no_strobe", 64'(mem_write | mem_read), 64'd0);
        check("rst_no_rsp", 64'(r0_rsp_valid | r1_rsp_valid), 64'd0);
        check("rst_write_committed", env_mem[4], 64'hCAFE);
        tick(2);

        // randomized traffic with random response backpressure
        rand_done = 1'b0;
        fork
            begin
                fork
                    rand_traffic(1'b0, 60);
                    rand_traffic(1'b1, 60);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    r0_rsp_ready = ($urandom_range(0, 3) != 0);
                    r1_rsp_ready = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
            end
        join
        r0_rsp_ready = 1'b1;
        r1_rsp_ready = 1'b1;
        tick(6);
        check("drained_idle", 64'(dbg_state), 64'(IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // hard stop in case something wedges beyond every bounded wait
    initial begin
        #400000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
